// File: rtl/conv_pkg.sv
// Shared definitions for the convolution layer scheduler: FSM state
// encoding and the layer mode encodings carried on cfg_mode / mode.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FINISH = 3'd5
    } conv_sched_state_t;

    localparam logic [1:0] MODE_CONV = 2'd0;  // standard convolution
    localparam logic [1:0] MODE_DW   = 2'd1;  // depthwise
    localparam logic [1:0] MODE_PW   = 2'd2;  // pointwise
    localparam logic [1:0] MODE_FC   = 2'd3;  // fully connected

    localparam int N_CHANNELS = 3;            // IF, filter, psum load channels

endpackage

// File: rtl/ld_channel.sv
// One load channel: counts accepted words up to a target and gates the
// buffer write enable / source ready on source valid and buffer ready.
// done is look-ahead: it is high in the cycle the final word is accepted,
// so the scheduler leaves LOAD right after the last write.
module ld_channel #(
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic                 active,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] target,
    input  logic                 src_valid,
    input  logic                 buff_ready,
    output logic                 wen,
    output logic                 done
);

    logic [CNT_WIDTH-1:0] cnt_reg;
    logic                 below;
    logic                 last_word;

    assign below     = (cnt_reg < target);
    assign wen       = active & en & below & src_valid & buff_ready;
    assign last_word = (({1'b0, cnt_reg} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, target});
    // A disabled channel never holds up the transition out of LOAD.
    assign done      = ~en | ~below | (wen & last_word);

    // Word counter: cleared at the start of each job, one step per accepted word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (wen) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// Layer scheduler for the Conv engine: accepts a layer config, clears the
// buffers, loads IF / filter / (optional) psum words concurrently, pulses
// start, drains the result stream and signals done. abort returns to IDLE
// through a full clear without done.
// Optional feature: define CONV_SCHED_PERF_EN to build the perf_cycles
// counter (LOAD+START+DRAIN cycles, saturating); otherwise it reads 0.
module conv_scheduler
    import conv_pkg::*;
#(
    parameter int N_WIDTH           = 4,
    parameter int IFMap_ADDR_WIDTH  = 6,
    parameter int FILTER_ADDR_WIDTH = 4,
    parameter int CNT_WIDTH         = 10
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [1:0]                   cfg_mode,
    input  logic [N_WIDTH-1:0]           cfg_n,
    input  logic [IFMap_ADDR_WIDTH-1:0]  cfg_stride,
    input  logic [FILTER_ADDR_WIDTH-1:0] cfg_filter_size,
    input  logic                         cfg_acc_psum,
    input  logic [CNT_WIDTH-1:0]         cfg_if_words,
    input  logic [CNT_WIDTH-1:0]         cfg_flt_words,
    input  logic [CNT_WIDTH-1:0]         cfg_psum_words,
    input  logic [CNT_WIDTH-1:0]         cfg_out_words,
    input  logic                         if_src_valid,
    input  logic                         flt_src_valid,
    input  logic                         psum_src_valid,
    output logic                         if_src_ready,
    output logic                         flt_src_ready,
    output logic                         psum_src_ready,
    input  logic                         IF_buff_ready,
    input  logic                         filter_buff_ready,
    input  logic                         in_Psum_buff_ready,
    input  logic                         Psum_buff_valid,
    output logic                         start,
    output logic                         IF_buff_clr,
    output logic                         IF_buff_wen,
    output logic                         filter_buff_clr,
    output logic                         filter_buff_wen,
    output logic                         in_Psum_buf_clear,
    output logic                         in_Psum_buff_wen,
    output logic                         Psum_buff_ren,
    output logic [1:0]                   mode,
    output logic [N_WIDTH-1:0]           n,
    output logic [IFMap_ADDR_WIDTH-1:0]  stride,
    output logic [FILTER_ADDR_WIDTH-1:0] filter_size,
    output logic                         acc_in_psum,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         abort,
    output logic                         done,
    output logic                         busy,
    output logic [31:0]                  perf_cycles
);

    conv_sched_state_t state_reg, state_next;
    logic                 abort_reg;
    logic [CNT_WIDTH-1:0] if_words_reg, flt_words_reg, psum_words_reg, out_words_reg;
    logic [CNT_WIDTH-1:0] out_cnt_reg;

    logic                 in_clear, in_load, accept_cfg, out_below, drain_done;
    logic [N_CHANNELS-1:0] ch_valid, ch_buff_ready, ch_en, ch_wen, ch_done;
    logic [CNT_WIDTH-1:0]  ch_target [N_CHANNELS];

    assign in_clear   = (state_reg == ST_CLEAR);
    assign in_load    = (state_reg == ST_LOAD);
    // Gated with rstn so the handshake is closed while reset is held.
    assign cfg_ready  = rstn & (state_reg == ST_IDLE);
    assign accept_cfg = cfg_valid & cfg_ready;

    // Channel order: 0 = IF, 1 = filter, 2 = psum.
    assign ch_valid      = {psum_src_valid, flt_src_valid, if_src_valid};
    assign ch_buff_ready = {in_Psum_buff_ready, filter_buff_ready, IF_buff_ready};
    assign ch_en         = {acc_in_psum, 1'b1, 1'b1};
    assign ch_target[0]  = if_words_reg;
    assign ch_target[1]  = flt_words_reg;
    assign ch_target[2]  = psum_words_reg;

    generate
        for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
            ld_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
                .clk        (clk),
                .rstn       (rstn),
                .clr        (in_clear),
                .active     (in_load),
                .en         (ch_en[gi]),
                .target     (ch_target[gi]),
                .src_valid  (ch_valid[gi]),
                .buff_ready (ch_buff_ready[gi]),
                .wen        (ch_wen[gi]),
                .done       (ch_done[gi])
            );
        end
    endgenerate

    assign IF_buff_wen      = ch_wen[0];
    assign if_src_ready     = ch_wen[0];
    assign filter_buff_wen  = ch_wen[1];
    assign flt_src_ready    = ch_wen[1];
    assign in_Psum_buff_wen = ch_wen[2];
    assign psum_src_ready   = ch_wen[2];

    assign IF_buff_clr       = in_clear;
    assign filter_buff_clr   = in_clear;
    assign in_Psum_buf_clear = in_clear & (acc_in_psum | abort_reg);

    assign out_below     = (out_cnt_reg < out_words_reg);
    assign Psum_buff_ren = (state_reg == ST_DRAIN) & out_below & Psum_buff_valid & out_ready;
    assign out_valid     = Psum_buff_ren;
    assign drain_done    = ~out_below |
        (Psum_buff_ren & (({1'b0, out_cnt_reg} + {{CNT_WIDTH{1'b0}}, 1'b1}) == {1'b0, out_words_reg}));

    assign start = (state_reg == ST_START);
    assign done  = (state_reg == ST_FINISH);
    assign busy  = (state_reg != ST_IDLE);

    // Next-state logic; abort outranks every completion condition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept_cfg) state_next = ST_CLEAR;
            ST_CLEAR:  state_next = abort_reg ? ST_IDLE : ST_LOAD;
            ST_LOAD:   if (&ch_done) state_next = ST_START;
            ST_START:  state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (abort && state_reg != ST_IDLE) begin
            state_next = ST_CLEAR;
        end
    end

    // State, abort marker, latched layer config and drain counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            abort_reg      <= 1'b0;
            mode           <= '0;
            n              <= '0;
            stride         <= '0;
            filter_size    <= '0;
            acc_in_psum    <= 1'b0;
            if_words_reg   <= '0;
            flt_words_reg  <= '0;
            psum_words_reg <= '0;
            out_words_reg  <= '0;
            out_cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (abort && state_reg != ST_IDLE) begin
                abort_reg <= 1'b1;
            end else if (in_clear) begin
                abort_reg <= 1'b0;
            end
            if (accept_cfg) begin
                mode           <= cfg_mode;
                n              <= cfg_n;
                stride         <= cfg_stride;
                filter_size    <= cfg_filter_size;
                acc_in_psum    <= cfg_acc_psum;
                if_words_reg   <= cfg_if_words;
                flt_words_reg  <= cfg_flt_words;
                psum_words_reg <= cfg_psum_words;
                out_words_reg  <= cfg_out_words;
            end
            if (in_clear) begin
                out_cnt_reg <= '0;
            end else if (Psum_buff_ren) begin
                out_cnt_reg <= out_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_reg;
    logic        perf_count;

    assign perf_count = (state_reg == ST_LOAD) | (state_reg == ST_START) | (state_reg == ST_DRAIN);

    // Active-job cycle counter, saturating, held from FINISH until next CLEAR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_reg <= '0;
        end else if (in_clear) begin
            perf_reg <= '0;
        end else if (perf_count && perf_reg != 32'hFFFF_FFFF) begin
            perf_reg <= perf_reg + 32'd1;
        end
    end

    assign perf_cycles = perf_reg;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
